// File: rtl/lcd_frame_writer.sv
// KS0108 128x64 frame refresher fed by the upstream column-byte stream.
// Define LCD_CLEAR_EN to blank all 8 pages once, right after start-up.
module lcd_frame_writer #(
   parameter int         RST_CYCLES = 16,
   parameter logic [5:0] START_LINE = 6'd0
) (
   input  logic       clk_div,
   input  logic       rst_n,
   input  logic [7:0] data_in,
   input  logic       data_valid,
   output logic       en,
   output logic [7:0] lcd_data,
   output logic       lcd_di,
   output logic       lcd_rw,
   output logic       lcd_e,
   output logic       lcd_cs1,
   output logic       lcd_cs2,
   output logic       lcd_rst,
   output logic [2:0] page,
   output logic       frame_done
);

   localparam int            RW       = $clog2(RST_CYCLES + 1);
   localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);

   typedef enum logic [3:0] {
      S_RST,
      S_INIT,
      S_START,
      S_PAGE,
      S_COL,
      S_REQ,
      S_WAIT,
      S_DATA
`ifdef LCD_CLEAR_EN
      , S_CLEAR
`endif
   } state_t;

   state_t        state_q;
   logic [1:0]    ph_q;
   logic [RW-1:0] rcnt_q;
   logic [5:0]    col_q;
   logic [2:0]    page_q;
   logic [2:0]    page_nx;
   logic          en_q;
   logic [7:0]    data_q;
   logic          di_q;
   logic          e_q;
   logic          cs_q;
   logic          lrst_q;
   logic          fd_q;
`ifdef LCD_CLEAR_EN
   logic          clr_q;
`endif

   assign page_nx    = page_q + 3'd1;
   assign en         = en_q;
   assign lcd_data   = data_q;
   assign lcd_di     = di_q;
   assign lcd_rw     = 1'b0;
   assign lcd_e      = e_q;
   assign lcd_cs1    = cs_q;
   assign lcd_cs2    = cs_q;
   assign lcd_rst    = lrst_q;
   assign page       = page_q;
   assign frame_done = fd_q;

   // Sequencer: reset hold, command/data bus cycles, byte requests.
   always_ff @(posedge clk_div or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_RST;
         ph_q    <= '0;
         rcnt_q  <= '0;
         col_q   <= '0;
         page_q  <= '0;
         en_q    <= 1'b0;
         data_q  <= '0;
         di_q    <= 1'b0;
         e_q     <= 1'b0;
         cs_q    <= 1'b0;
         lrst_q  <= 1'b0;
         fd_q    <= 1'b0;
`ifdef LCD_CLEAR_EN
         clr_q   <= 1'b0;
`endif
      end else begin
         en_q <= 1'b0;
         fd_q <= 1'b0;
         unique case (state_q)
            S_RST: begin
               if (rcnt_q == RST_LAST) begin
                  lrst_q  <= 1'b1;
                  cs_q    <= 1'b1;
                  di_q    <= 1'b0;
                  data_q  <= 8'h3F;
                  ph_q    <= 2'd0;
                  state_q <= S_INIT;
               end else begin
                  rcnt_q <= rcnt_q + 1'b1;
               end
            end
            S_REQ: state_q <= S_WAIT;
            S_WAIT: begin
               if (data_valid) begin
                  data_q  <= data_in;
                  di_q    <= 1'b1;
                  ph_q    <= 2'd0;
                  state_q <= S_DATA;
               end else begin
                  en_q    <= 1'b1;
                  state_q <= S_REQ;
               end
            end
            default: begin
               case (ph_q)
                  2'd0: begin
                     e_q  <= 1'b1;
                     ph_q <= 2'd1;
                  end
                  2'd1: begin
                     e_q  <= 1'b0;
                     ph_q <= 2'd2;
                     if (state_q == S_DATA && col_q == 6'd63 &&
                         page_q == 3'd7)
                        fd_q <= 1'b1;
                  end
                  default: begin
                     ph_q <= 2'd0;
                     case (state_q)
                        S_INIT: begin
                           data_q  <= {2'b11, START_LINE};
                           state_q <= S_START;
                        end
                        S_START: begin
                           data_q  <= {5'b10111, page_q};
                           state_q <= S_PAGE;
`ifdef LCD_CLEAR_EN
                           clr_q   <= 1'b1;
`endif
                        end
                        S_PAGE: begin
                           data_q  <= 8'h40;
                           col_q   <= 6'd0;
                           state_q <= S_COL;
                        end
                        S_COL: begin
`ifdef LCD_CLEAR_EN
                           if (clr_q) begin
                              data_q  <= 8'h00;
                              di_q    <= 1'b1;
                              state_q <= S_CLEAR;
                           end else begin
                              en_q    <= 1'b1;
                              state_q <= S_REQ;
                           end
`else
                           en_q    <= 1'b1;
                           state_q <= S_REQ;
`endif
                        end
                        S_DATA: begin
                           col_q <= col_q + 6'd1;
                           if (col_q == 6'd63) begin
                              page_q  <= page_nx;
                              data_q  <= {5'b10111, page_nx};
                              di_q    <= 1'b0;
                              state_q <= S_PAGE;
                           end else begin
                              en_q    <= 1'b1;
                              state_q <= S_REQ;
                           end
                        end
`ifdef LCD_CLEAR_EN
                        S_CLEAR: begin
                           col_q <= col_q + 6'd1;
                           if (col_q == 6'd63) begin
                              page_q  <= page_nx;
                              data_q  <= {5'b10111, page_nx};
                              di_q    <= 1'b0;
                              state_q <= S_PAGE;
                              if (page_q == 3'd7)
                                 clr_q <= 1'b0;
                           end else begin
                              data_q <= 8'h00;
                           end
                        end
`endif
                        default: state_q <= S_RST;
                     endcase
                  end
               endcase
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_frame_writer.sv
// Bench for lcd_frame_writer: random upstream timing and bytes checked
// against the expected LCD write sequence derived from page/column math.
module tb_lcd_frame_writer;

   logic       clk_div = 1'b0;
   logic       rst_n;
   logic [7:0] data_in;
   logic       data_valid;
   logic       en;
   logic [7:0] lcd_data;
   logic       lcd_di;
   logic       lcd_rw;
   logic       lcd_e;
   logic       lcd_cs1;
   logic       lcd_cs2;
   logic       lcd_rst;
   logic [2:0] page;
   logic       frame_done;

   int checks = 0;
   int errors = 0;

   always #5 clk_div = ~clk_div;

   lcd_frame_writer dut (
      .clk_div    (clk_div),
      .rst_n      (rst_n),
      .data_in    (data_in),
      .data_valid (data_valid),
      .en         (en),
      .lcd_data   (lcd_data),
      .lcd_di     (lcd_di),
      .lcd_rw     (lcd_rw),
      .lcd_e      (lcd_e),
      .lcd_cs1    (lcd_cs1),
      .lcd_cs2    (lcd_cs2),
      .lcd_rst    (lcd_rst),
      .page       (page),
      .frame_done (frame_done)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk_div);
   endtask

   // One bus write: entered at the negedge showing SETUP, left one
   // negedge after HOLD. Upstream noise on data_valid must be ignored.
   task automatic xact(input string tag, input logic di,
                       input logic [7:0] d, input logic fd);
      for (int p = 0; p < 3; p++) begin
         chk({tag, " e"}, 32'(lcd_e), (p == 1) ? 32'd1 : 32'd0);
         chk({tag, " di"}, 32'(lcd_di), 32'(di));
         chk({tag, " data"}, 32'(lcd_data), 32'(d));
         chk({tag, " en"}, 32'(en), 32'd0);
         chk({tag, " fd"}, 32'(frame_done), (p == 2) ? 32'(fd) : 32'd0);
         chk({tag, " cs"}, 32'({lcd_cs1, lcd_cs2, lcd_rw}), 32'b110);
         data_valid = 1'($urandom_range(0, 1));
         data_in    = 8'($urandom);
         tick();
      end
      data_valid = 1'b0;
   endtask

   // Upstream: answer the current en pulse after 'skip' ignored pulses.
   task automatic give_byte(input logic [7:0] b, input int skip);
      chk("req en", 32'(en), 32'd1);
      for (int i = 0; i < skip; i++) begin
         data_valid = 1'($urandom_range(0, 1));
         data_in    = 8'($urandom);
         tick();
         data_valid = 1'b0;
         chk("wait en", 32'(en), 32'd0);
         chk("wait e", 32'(lcd_e), 32'd0);
         tick();
         chk("repulse en", 32'(en), 32'd1);
         chk("repulse e", 32'(lcd_e), 32'd0);
      end
      data_valid = 1'($urandom_range(0, 1));
      data_in    = 8'($urandom);
      tick();
      chk("wait en", 32'(en), 32'd0);
      data_valid = 1'b1;
      data_in    = b;
      tick();
      data_valid = 1'b0;
   endtask

   // Called at the negedge where rst_n is released.
   task automatic init_seq();
      for (int i = 0; i < 16; i++) begin
         chk("rst hold", 32'(lcd_rst), 32'd0);
         chk("rst en", 32'(en), 32'd0);
         tick();
      end
      chk("rst done", 32'(lcd_rst), 32'd1);
      xact("init", 1'b0, 8'h3F, 1'b0);
      xact("start", 1'b0, 8'hC0, 1'b0);
`ifdef LCD_CLEAR_EN
      for (int p = 0; p < 8; p++) begin
         chk("clr page", 32'(page), 32'(p));
         xact("clr pcmd", 1'b0, 8'hB8 | 8'(p), 1'b0);
         xact("clr ccmd", 1'b0, 8'h40, 1'b0);
         for (int c = 0; c < 64; c++)
            xact("clr data", 1'b1, 8'h00, 1'b0);
      end
`endif
      chk("first page", 32'(page), 32'd0);
      xact("page0", 1'b0, 8'hB8, 1'b0);
      xact("col0", 1'b0, 8'h40, 1'b0);
   endtask

   initial begin
      logic [7:0] b;
      int         skip;
      int         pg;
      rst_n      = 1'b0;
      data_valid = 1'b0;
      data_in    = 8'h00;
      repeat (3) tick();
      chk("rst en", 32'(en), 32'd0);
      chk("rst data", 32'(lcd_data), 32'd0);
      chk("rst di", 32'(lcd_di), 32'd0);
      chk("rst rw", 32'(lcd_rw), 32'd0);
      chk("rst e", 32'(lcd_e), 32'd0);
      chk("rst cs1", 32'(lcd_cs1), 32'd0);
      chk("rst cs2", 32'(lcd_cs2), 32'd0);
      chk("rst lcd_rst", 32'(lcd_rst), 32'd0);
      chk("rst page", 32'(page), 32'd0);
      chk("rst fd", 32'(frame_done), 32'd0);
      rst_n = 1'b1;
      init_seq();

      // Frame-and-a-bit of bytes; model: byte k sits at page (k/64)%8,
      // column k%64; each page starts with B8|page then 40.
      for (int k = 0; k < 581; k++) begin
         pg = (k / 64) % 8;
         if (k % 64 == 0 && k > 0) begin
            chk("page out", 32'(page), 32'(pg));
            xact("page cmd", 1'b0, 8'hB8 | 8'(pg), 1'b0);
            xact("col cmd", 1'b0, 8'h40, 1'b0);
         end
         chk("page", 32'(page), 32'(pg));
         b    = (k == 0) ? 8'hA5 : 8'($urandom);
         skip = (k == 0) ? 0 : (k == 1) ? 4 : int'($urandom_range(0, 2));
         give_byte(b, skip);
         xact("data", 1'b1, b, 1'((k % 512) == 511));
      end

      // Reset in the middle of an E-high phase.
      give_byte(8'h5A, 0);
      tick();
      chk("pre-rst e", 32'(lcd_e), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async e", 32'(lcd_e), 32'd0);
      chk("async lcd_rst", 32'(lcd_rst), 32'd0);
      chk("async cs", 32'({lcd_cs1, lcd_cs2}), 32'd0);
      chk("async data", 32'(lcd_data), 32'd0);
      chk("async di", 32'(lcd_di), 32'd0);
      chk("async page", 32'(page), 32'd0);
      tick();
      rst_n = 1'b1;
      init_seq();
      b = 8'($urandom);
      give_byte(b, 1);
      xact("post data", 1'b1, b, 1'b0);
      chk("post en", 32'(en), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
